control_juego: RTL

//  Top-level game sequencer: owns state `presente` and result `W_or_L`, which drive generador_obstaculos.

---
 rtl/juego_pkg.sv | 17 +
 rtl/control_juego_if.sv | 23 ++
 rtl/temporizador_seg.sv | 39 +++
 rtl/control_juego.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/juego_pkg.sv
// Shared game encodings for control_juego and generador_obstaculos.
package juego_pkg;

    typedef enum logic [2:0] {
        OFF  = 3'd0,
        WLCM = 3'd1,
        CH   = 3'd2,
        GAME = 3'd3,
        WL   = 3'd4,
        PA   = 3'd5
    } estado_t;

    localparam logic [1:0] W_OR_L_JUEGO  = 2'b00;
    localparam logic [1:0] W_OR_L_PIERDE = 2'b01;
    localparam logic [1:0] W_OR_L_GANA   = 2'b10;

endpackage

// File: rtl/control_juego_if.sv
// Player inputs and game-status outputs of the sequencer.
// master drives buttons/choque/mundo; slave is control_juego.
interface control_juego_if;
    logic       btn_power;
    logic       btn_start;
    logic       btn_pausa;
    logic       choque;
    logic [1:0] mundo;
    logic [2:0] presente;
    logic [1:0] W_or_L;
    logic [1:0] vidas;
    logic [3:0] seg_restantes;

    modport master (
        output btn_power, btn_start, btn_pausa, choque, mundo,
        input  presente, W_or_L, vidas, seg_restantes
    );

    modport slave (
        input  btn_power, btn_start, btn_pausa, choque, mundo,
        output presente, W_or_L, vidas, seg_restantes
    );
endinterface

// File: rtl/temporizador_seg.sv
// Loadable seconds down-counter with a CLK_HZ prescaler; fin pulses on the
// tick that takes seg from 1 to 0.
module temporizador_seg #(
    parameter int unsigned CLK_HZ = 27_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] valor,
    output logic [3:0] seg,
    output logic       fin
);
    localparam int unsigned CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CLK_HZ - 1);

    logic [CW-1:0] cnt_q;
    logic          tick;

    assign tick = (seg != 4'd0) && (cnt_q == CNT_MAX);
    assign fin  = tick && (seg == 4'd1) && !load;

    // Prescaler idles at 0 once seg reaches 0, so every load starts a full second.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            seg   <= 4'd0;
        end else if (load) begin
            cnt_q <= '0;
            seg   <= valor;
        end else if (seg != 4'd0) begin
            if (tick) begin
                cnt_q <= '0;
                seg   <= seg - 4'd1;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end
endmodule

// File: rtl/control_juego.sv
// Game sequencer: OFF -> WLCM -> CH -> GAME -> WL, lives and screen timing.
// Define CTRL_PAUSA_EN to compile in the PA state and btn_pausa handling.
module control_juego
    import juego_pkg::*;
#(
    parameter int unsigned CLK_HZ = 27_000_000,
    parameter int unsigned T_WLCM = 3,
    parameter int unsigned T_WL   = 5,
    parameter int unsigned VIDAS  = 3
) (
    input logic             clk,
    input logic             rst,
    control_juego_if.slave  bus
);
    localparam logic [3:0] T_WLCM_V = 4'(T_WLCM);
    localparam logic [3:0] T_WL_V   = 4'(T_WL);
    localparam logic [1:0] VIDAS_V  = 2'(VIDAS);

    estado_t    estado_q;
    logic [1:0] wl_q;
    logic [1:0] vidas_q;

    logic [1:0] power_sync, start_sync;
    logic       power_prev, start_prev, choque_q;
    logic       power_edge, start_edge, choque_edge, pausa_edge;
    logic       lose, win;
    logic       tmr_load, tmr_fin;
    logic [3:0] tmr_val, tmr_seg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            power_sync <= 2'b00;
            start_sync <= 2'b00;
            power_prev <= 1'b0;
            start_prev <= 1'b0;
            choque_q   <= 1'b0;
        end else begin
            power_sync <= {power_sync[0], bus.btn_power};
            start_sync <= {start_sync[0], bus.btn_start};
            power_prev <= power_sync[1];
            start_prev <= start_sync[1];
            choque_q   <= bus.choque;
        end
    end

    assign power_edge  = power_sync[1] & ~power_prev;
    assign start_edge  = start_sync[1] & ~start_prev;
    assign choque_edge = bus.choque & ~choque_q;

`ifdef CTRL_PAUSA_EN
    logic [1:0] pausa_sync;
    logic       pausa_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pausa_sync <= 2'b00;
            pausa_prev <= 1'b0;
        end else begin
            pausa_sync <= {pausa_sync[0], bus.btn_pausa};
            pausa_prev <= pausa_sync[1];
        end
    end

    assign pausa_edge = pausa_sync[1] & ~pausa_prev;
`else
    logic unused_pausa;
    assign unused_pausa = bus.btn_pausa;
    assign pausa_edge   = 1'b0;
`endif

    assign lose = choque_edge && (vidas_q == 2'd1);
    assign win  = (bus.mundo == 2'd3);

    // Timer is loaded on the same edge the FSM enters WLCM/WL; power-off clears it.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = 4'd0;
        if (power_edge) begin
            tmr_load = 1'b1;
            tmr_val  = (estado_q == OFF) ? T_WLCM_V : 4'd0;
        end else if ((estado_q == GAME) && (lose || win)) begin
            tmr_load = 1'b1;
            tmr_val  = T_WL_V;
        end
    end

    temporizador_seg #(
        .CLK_HZ (CLK_HZ)
    ) u_temporizador (
        .clk   (clk),
        .rst   (rst),
        .load  (tmr_load),
        .valor (tmr_val),
        .seg   (tmr_seg),
        .fin   (tmr_fin)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado_q <= OFF;
            wl_q     <= W_OR_L_JUEGO;
            vidas_q  <= 2'd0;
        end else if (power_edge) begin
            estado_q <= (estado_q == OFF) ? WLCM : OFF;
            wl_q     <= W_OR_L_JUEGO;
            vidas_q  <= 2'd0;
        end else begin
            case (estado_q)
                OFF: ;
                WLCM: begin
                    if (tmr_fin) estado_q <= CH;
                end
                CH: begin
                    if (start_edge) begin
                        estado_q <= GAME;
                        vidas_q  <= VIDAS_V;
                        wl_q     <= W_OR_L_JUEGO;
                    end
                end
                // Lose is checked before win so a fatal hit on the last world still loses.
                GAME: begin
                    if (lose) begin
                        estado_q <= WL;
                        wl_q     <= W_OR_L_PIERDE;
                        vidas_q  <= 2'd0;
                    end else if (win) begin
                        estado_q <= WL;
                        wl_q     <= W_OR_L_GANA;
                    end else if (choque_edge) begin
                        vidas_q <= vidas_q - 2'd1;
                    end else if (pausa_edge) begin
                        estado_q <= PA;
                    end
                end
                WL: begin
                    if (tmr_fin) begin
                        estado_q <= CH;
                        wl_q     <= W_OR_L_JUEGO;
                    end
                end
`ifdef CTRL_PAUSA_EN
                PA: begin
                    if (pausa_edge) estado_q <= GAME;
                end
`endif
                default: estado_q <= OFF;
            endcase
        end
    end

    assign bus.presente      = estado_q;
    assign bus.W_or_L        = wl_q;
    assign bus.vidas         = vidas_q;
    assign bus.seg_restantes = tmr_seg;
endmodule
